// File: rtl/and_gate_pkg.sv
// and_gate_pkg: shared constants and types for the and_gate unit.
//   AND_GATE_DEFAULT_WIDTH : default operand/result width.
//   AND_GATE_LATENCY       : registered-path latency (1, or 2 with AND_GATE_PIPE_EN).
//   and_gate_flags_t       : control half of a stage bundle {valid, all_ones, any_one};
//                            the data half travels beside it because its width is
//                            a per-instance parameter.
// Optional macro: AND_GATE_PIPE_EN adds a second register stage.
package and_gate_pkg;

    localparam int AND_GATE_DEFAULT_WIDTH = 1;

`ifdef AND_GATE_PIPE_EN
    localparam int AND_GATE_LATENCY = 2;
`else
    localparam int AND_GATE_LATENCY = 1;
`endif

    typedef struct packed {
        logic valid;
        logic all_ones;
        logic any_one;
    } and_gate_flags_t;

endpackage

// File: rtl/and_gate_stage.sv
// and_gate_stage: one register stage of the and_gate result pipeline.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears everything).
//   flags_d   : incoming {valid, all_ones, any_one}.
//   data_d    : incoming WIDTH-bit result.
//   flags_q   : registered flags; valid follows flags_d.valid every cycle.
//   data_q    : registered result.
// Data and reduction flags only load on a valid input, so garbage on an
// invalid cycle never reaches the held values.
module and_gate_stage
    import and_gate_pkg::*;
#(
    parameter int WIDTH = AND_GATE_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  and_gate_flags_t  flags_d,
    input  logic [WIDTH-1:0] data_d,
    output and_gate_flags_t  flags_q,
    output logic [WIDTH-1:0] data_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            data_q  <= '0;
        end else begin
            flags_q.valid <= flags_d.valid;
            if (flags_d.valid) begin
                flags_q.all_ones <= flags_d.all_ones;
                flags_q.any_one  <= flags_d.any_one;
                data_q           <= data_d;
            end
        end
    end

endmodule

// File: rtl/and_gate.sv
// and_gate: parameterised bitwise two-operand AND with a combinational result
// and a registered, valid-qualified result carrying reduction flags.
// Ports:
//   clk, rst          : clock, synchronous active-high reset.
//   in_valid          : qualifies input_1/input_2 for capture.
//   input_1, input_2  : WIDTH-bit operands.
//   out_comb          : input_1 & input_2, zero latency, ignores in_valid/rst.
//   out               : registered AND result.
//   out_valid         : out was captured from a valid input.
//   all_ones, any_one : registered reduction AND / OR of the captured result.
// Optional macro: AND_GATE_PIPE_EN adds a second stage (latency 2).
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = AND_GATE_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    output logic [WIDTH-1:0] out_comb,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             all_ones,
    output logic             any_one
);

    logic [WIDTH-1:0] and_res;

    // Element 0 is the unregistered head; element N is stage N's output.
    and_gate_flags_t  flag_pipe [AND_GATE_LATENCY+1];
    logic [WIDTH-1:0] data_pipe [AND_GATE_LATENCY+1];

    assign and_res  = input_1 & input_2;
    assign out_comb = and_res;

    // Reductions are formed once at the head; later stages just carry them.
    assign flag_pipe[0] = '{valid: in_valid, all_ones: &and_res, any_one: |and_res};
    assign data_pipe[0] = and_res;

    genvar i;
    generate
        for (i = 0; i < AND_GATE_LATENCY; i++) begin : g_stage
            and_gate_stage #(.WIDTH(WIDTH)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .flags_d (flag_pipe[i]),
                .data_d  (data_pipe[i]),
                .flags_q (flag_pipe[i+1]),
                .data_q  (data_pipe[i+1])
            );
        end
    endgenerate

    assign out       = data_pipe[AND_GATE_LATENCY];
    assign out_valid = flag_pipe[AND_GATE_LATENCY].valid;
    assign all_ones  = flag_pipe[AND_GATE_LATENCY].all_ones;
    assign any_one   = flag_pipe[AND_GATE_LATENCY].any_one;

endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: directed self-checking bench for and_gate, with a WIDTH=1
// instance (truth table, reset) and a WIDTH=8 instance (hold, flags, throughput).
// Latency follows AND_GATE_PIPE_EN so the same bench covers both builds.
module tb_and_gate;

`ifdef AND_GATE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v1, a1, b1, oc1, o1, ov1, ao1, an1;
    logic       v8, ov8, ao8, an8;
    logic [7:0] a8, b8, oc8, o8;

    and_gate #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .input_1(a1), .input_2(b1),
        .out_comb(oc1), .out(o1), .out_valid(ov1), .all_ones(ao1), .any_one(an1)
    );

    and_gate #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .input_1(a8), .input_2(b8),
        .out_comb(oc8), .out(o8), .out_valid(ov8), .all_ones(ao8), .any_one(an8)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sa [16];
    logic [7:0] sb [16];

    // Drive n back-to-back valid pairs from sa/sb into one instance and check
    // each result LAT edges after its sample.
    task automatic stream(input bit w8, input int n);
        logic [7:0] e;
        int idx;
        for (int c = 0; c < n + LAT - 1; c++) begin
            if (c < n) begin
                if (w8) begin v8 = 1'b1; a8 = sa[c]; b8 = sb[c]; end
                else    begin v1 = 1'b1; a1 = sa[c][0]; b1 = sb[c][0]; end
                #1;
                e = sa[c] & sb[c];
                if (w8) chk("comb8", 64'(oc8), 64'(e));
                else    chk("comb1", 64'(oc1), 64'(e[0]));
            end else begin
                v1 = 1'b0; v8 = 1'b0;
            end
            tick;
            idx = c - LAT + 1;
            if (idx >= 0) begin
                e = sa[idx] & sb[idx];
                if (w8) begin
                    chk("out8",       64'(o8),  64'(e));
                    chk("out_valid8", 64'(ov8), 64'd1);
                    chk("all_ones8",  64'(ao8), 64'(e == 8'hFF));
                    chk("any_one8",   64'(an8), 64'(e != 8'h00));
                end else begin
                    chk("out1",       64'(o1),  64'(e[0]));
                    chk("out_valid1", 64'(ov1), 64'd1);
                end
            end
        end
        v1 = 1'b0; v8 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        tick; tick;

        // reset state
        chk("rst_out8",   64'(o8),  64'd0);
        chk("rst_valid8", 64'(ov8), 64'd0);
        chk("rst_all8",   64'(ao8), 64'd0);
        chk("rst_any8",   64'(an8), 64'd0);
        chk("rst_valid1", 64'(ov1), 64'd0);
        rst = 1'b0;

        // truth table: (1,0),(0,1),(1,1),(0,0) -> 0,0,1,0
        sa[0] = 8'd1; sb[0] = 8'd0;
        sa[1] = 8'd0; sb[1] = 8'd1;
        sa[2] = 8'd1; sb[2] = 8'd1;
        sa[3] = 8'd0; sb[3] = 8'd0;
        stream(1'b0, 4);
        tick;
        chk("tt_idle_valid", 64'(ov1), 64'd0);
        chk("tt_idle_hold",  64'(o1),  64'd0);

        // reset after loading (1,1)
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        tick;
        v1 = 1'b0;
        repeat (LAT - 1) tick;
        chk("load_out",   64'(o1),  64'd1);
        chk("load_valid", 64'(ov1), 64'd1);
        chk("load_all",   64'(ao1), 64'd1);
        rst = 1'b1;
        tick;
        chk("rst1_out",   64'(o1),  64'd0);
        chk("rst1_valid", 64'(ov1), 64'd0);
        chk("rst1_all",   64'(ao1), 64'd0);
        chk("rst1_any",   64'(an1), 64'd0);
        // reset wins over a valid input
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        tick;
        chk("rstv_out",   64'(o1),  64'd0);
        chk("rstv_valid", 64'(ov1), 64'd0);
        chk("rstv_all",   64'(ao1), 64'd0);
        chk("rstv_any",   64'(an1), 64'd0);
        rst = 1'b0;
        tick;
        v1 = 1'b0;
        repeat (LAT - 1) tick;
        chk("post_rst_out",   64'(o1),  64'd1);
        chk("post_rst_valid", 64'(ov1), 64'd1);

        // hold: 0xF0 & 0x3C = 0x30, then invalid cycles with changing operands
        v8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
        tick;
        v8 = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            if (k == 2) begin a8 = 'x; b8 = 'x; end
            else        begin a8 = 8'(k * 37); b8 = 8'hFF; end
            tick;
            if (k >= LAT) begin
                chk("hold_out",   64'(o8),  64'h30);
                chk("hold_valid", 64'(ov8), 64'd0);
                chk("hold_any",   64'(an8), 64'd1);
                chk("hold_all",   64'(ao8), 64'd0);
            end
        end

        // reduction flags: FF&FF -> all/any set; AA&55 -> 00, both clear
        sa[0] = 8'hFF; sb[0] = 8'hFF;
        sa[1] = 8'hAA; sb[1] = 8'h55;
        stream(1'b1, 2);
        chk("red_zero_out", 64'(o8),  64'h00);
        chk("red_zero_all", 64'(ao8), 64'd0);
        chk("red_zero_any", 64'(an8), 64'd0);

        // throughput: 16 back-to-back random pairs
        for (int i = 0; i < 16; i++) begin
            sa[i] = 8'($urandom_range(0, 255));
            sb[i] = 8'($urandom_range(0, 255));
        end
        stream(1'b1, 16);
        tick;
        chk("tp_idle_valid", 64'(ov8), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/and_gate.md
Name: and_gate

Overview:
- Parameterised bitwise two-operand AND unit; the clocked replacement for the original single-bit And primitive.
- Provides two result paths for logic, datapath-masking and test structures:
  - a combinational result;
  - a registered, valid-qualified result with reduction flags.
- WIDTH=1 reproduces the classic 2-input AND truth table.

Parameters:
- WIDTH, 1, operand/result bit width (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- in_valid  input  1  qualifies input_1/input_2 for capture this cycle.
- input_1  input  WIDTH  operand A.
- input_2  input  WIDTH  operand B.
- out_comb  output  WIDTH  combinational input_1 & input_2; ignores in_valid and rst.
- out  output  WIDTH  registered AND result.
- out_valid  output  1  out holds a result captured from a valid input.
- all_ones  output  1  registered reduction-AND of the captured result.
- any_one  output  1  registered reduction-OR of the captured result.

Behaviour:
- Combinational path: out_comb = input_1 & input_2, bitwise, zero latency.
  - For WIDTH=1: 0&0=0, 1&0=0, 0&1=0, 1&1=1.
- Registered path: latency 1 cycle from an in_valid sample to out/out_valid.
- Reset, when rst=1 at a rising edge:
  - out, out_valid, all_ones and any_one all clear to 0.
  - rst has priority over in_valid.
- Normal operation, when rst=0 at a rising edge:
  - out_valid <= in_valid.
  - If in_valid=1: out <= input_1 & input_2; all_ones <= &(input_1 & input_2); any_one <= |(input_1 & input_2).
  - If in_valid=0: out, all_ones and any_one hold their previous values; only out_valid drops.
- Back-to-back valid inputs give one result per cycle; there is no backpressure and no stall.
- Reset mid-stream: a result captured before reset is discarded. The first valid result after reset appears one cycle after the first in_valid with rst=0.
- X/undriven operands with in_valid=0 must not corrupt the held registers.
- No internal state beyond the output registers (plus the pipe stage when enabled).

Optional Feature:
- Macro: AND_GATE_PIPE_EN.
- Defined:
  - Adds a second register stage after the first.
  - Registered-path latency becomes 2 cycles.
  - out_valid, all_ones and any_one are delayed to stay aligned with out.
  - Hold-on-invalid applies per stage.
  - Reset clears both stages.
  - out_comb is unaffected.
- Undefined: single stage, latency 1, exactly as in Behaviour.

Decomposition:
- Package and_gate_pkg:
  - AND_GATE_DEFAULT_WIDTH = 1.
  - AND_GATE_LATENCY: 1, or 2 under AND_GATE_PIPE_EN.
  - Typedef for the {valid, all_ones, any_one, data} stage bundle.
- One natural sub-module: and_gate_stage.
  - Contents: a WIDTH-wide register with valid, hold-on-invalid and sync reset, carrying the stage bundle.
  - Instantiated once, or twice when AND_GATE_PIPE_EN is defined.
  - Reduction flags are computed once, before the first stage.

Test Plan:
- Truth table, WIDTH=1, one valid sample per cycle:
  - Stimulus (1,0), (0,1), (1,1), (0,0).
  - out_comb is 0,0,1,0 immediately.
  - out is 0,0,1,0 and out_valid=1, each one cycle later.
- Reset:
  - After loading (1,1), assert rst for one cycle.
  - out=0, out_valid=0, all_ones=0, any_one=0 on the next edge.
  - rst together with in_valid=1 still yields all zeros.
- Hold, WIDTH=8:
  - Capture 0xF0 & 0x3C = 0x30, then drop in_valid and change the operands for 3 cycles.
  - out stays 0x30; out_valid=0; any_one=1; all_ones=0.
- Reduction flags, WIDTH=8:
  - 0xFF & 0xFF gives all_ones=1, any_one=1.
  - 0xAA & 0x55 gives out=0x00, all_ones=0, any_one=0.
- Throughput:
  - 16 consecutive random valid pairs, WIDTH=8.
  - Every cycle out matches the scoreboard a&b at the fixed latency, with out_valid continuously 1.
- Pipe option: rerun the truth-table case with AND_GATE_PIPE_EN defined; results appear after exactly 2 cycles.
